// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: opcodes, controller state, hazard classes and stage-control bundle
package cpu_types_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  typedef enum logic [1:0] {S_RUN, S_HAZ, S_HALT} state_t;
  typedef enum logic [1:0] {HZ_NONE, HZ_STALL1, HZ_STALL2} haz_t;

  typedef struct packed {
    logic pc_en;
    logic ifde_en;
    logic deex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifde_flush;
    logic deex_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN   = 7'b11111_00;
  localparam stage_ctrl_t CTRL_OFF   = 7'b00000_00;
  localparam stage_ctrl_t CTRL_STALL = 7'b00111_01;
  localparam stage_ctrl_t CTRL_MISS  = 7'b01111_10;
  localparam stage_ctrl_t CTRL_REDIR = 7'b11111_10;

  function automatic logic reads_rt(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW;
  endfunction
endpackage

// File: rtl/pipeline_controller_if.sv
// pipeline_controller_if: controller <-> datapath signal bundle
// pc: controller view (hit/hazard inputs, enables/flushes/halt/counter outputs); dp: datapath view
interface pipeline_controller_if #(parameter int CNT_W = 32);
  logic ihit, dhit, mem_dREN, mem_dWEN, mem_halt;
  logic [31:0] dec_instr;
  logic ex_dREN, ex_rfWEN;
  logic [4:0] ex_dest, mem_dREN_dest;
  logic branch_taken, jump;
  logic pc_en, ifde_en, deex_en, exmem_en, memwb_en;
  logic ifde_flush, deex_flush, halt;
  logic [CNT_W-1:0] stall_cycles;
  modport pc (
    input ihit, dhit, mem_dREN, mem_dWEN, mem_halt, dec_instr, ex_dREN, ex_rfWEN, ex_dest,
          mem_dREN_dest, branch_taken, jump,
    output pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush, deex_flush, halt, stall_cycles
  );
  modport dp (
    output ihit, dhit, mem_dREN, mem_dWEN, mem_halt, dec_instr, ex_dREN, ex_rfWEN, ex_dest,
           mem_dREN_dest, branch_taken, jump,
    input pc_en, ifde_en, deex_en, exmem_en, memwb_en, ifde_flush, deex_flush, halt, stall_cycles
  );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: classifies decode-stage RAW/branch dependencies as none, one or two stall cycles
// in: decode op/rs/rt, ex load/write/dest, mem load dest, in_haz; out: haz class
module hazard_detect import cpu_types_pkg::*; (
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_dREN,
  input  logic       ex_rfWEN,
  input  logic [4:0] ex_dest,
  input  logic [4:0] mem_dREN_dest,
  input  logic       in_haz,
  output haz_t       haz
);
  logic br, ex_use, mem_use;
  assign br = op == OP_BEQ || op == OP_BNE;
  assign ex_use = ex_dest != '0 && (ex_dest == rs || (reads_rt(op) && ex_dest == rt));
  assign mem_use = mem_dREN_dest != '0 && (mem_dREN_dest == rs || (reads_rt(op) && mem_dREN_dest == rt));
  // a branch waiting on an ex load needs the value from the load's wb, hence two bubbles
  assign haz = (ex_dREN && ex_use) ? (br ? HZ_STALL2 : HZ_STALL1) :
               (br && ((ex_rfWEN && ex_use) || (!in_haz && mem_use))) ? HZ_STALL1 : HZ_NONE;
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stage enables/flushes, halt and stall counter for a 5-stage pipeline
// CLK/nRST: clock and async active-low reset; bus (pc modport): hit/hazard inputs, control outputs
module pipeline_controller import cpu_types_pkg::*; #(
  parameter int CNT_W = 32
) (
  input logic CLK,
  input logic nRST,
  pipeline_controller_if.pc bus
);
  state_t state, nxt;
  haz_t hz;
  stage_ctrl_t c;
  logic dwait, unused_ok;
  logic [CNT_W-1:0] cnt;
  assign unused_ok = ^bus.dec_instr[15:0];
  assign dwait = (bus.mem_dREN || bus.mem_dWEN) && !bus.dhit;
  hazard_detect u_hd (
    .op(bus.dec_instr[31:26]),
    .rs(bus.dec_instr[25:21]),
    .rt(bus.dec_instr[20:16]),
    .ex_dREN(bus.ex_dREN),
    .ex_rfWEN(bus.ex_rfWEN),
    .ex_dest(bus.ex_dest),
    .mem_dREN_dest(bus.mem_dREN_dest),
    .in_haz(state == S_HAZ),
    .haz(hz)
  );
  always_comb begin
    c = CTRL_RUN;
    nxt = state;
    if (!nRST || state == S_HALT || dwait) c = CTRL_OFF;
    else begin
      if (state == S_HAZ || hz != HZ_NONE) c = CTRL_STALL;
      else if (!bus.ihit) c = CTRL_MISS;
      else if (bus.branch_taken || bus.jump) c = CTRL_REDIR;
      nxt = bus.mem_halt ? S_HALT : (state == S_RUN && hz == HZ_STALL2) ? S_HAZ : S_RUN;
    end
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= S_RUN;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state != S_HALT && !c.pc_en && !(&cnt)) cnt <= cnt + CNT_W'(1);
    end
  assign bus.pc_en = c.pc_en;
  assign bus.ifde_en = c.ifde_en;
  assign bus.deex_en = c.deex_en;
  assign bus.exmem_en = c.exmem_en;
  assign bus.memwb_en = c.memwb_en;
  assign bus.ifde_flush = c.ifde_flush;
  assign bus.deex_flush = c.deex_flush;
  assign bus.halt = state == S_HALT;
  assign bus.stall_cycles = cnt;
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed and randomized checks of pipeline_controller against a reference model
module tb_pipeline_controller;
  import cpu_types_pkg::*;
  localparam int W = 5;
  localparam int CMAX = 31;
  localparam logic [7:0] RUN = 8'b11111_00_0, STL = 8'b00111_01_0, MISS = 8'b01111_10_0,
                         RDR = 8'b11111_10_0, OFF = 8'b00000_00_0, HLT = 8'b00000_00_1;
  logic clk = 0, nrst = 0;
  int n_chk = 0, n_pass = 0;
  int owed = 0, cnt_m = 0;
  bit halted = 0;
  logic [5:0] ops [7] = '{OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW, OP_J, OP_ADDI};
  pipeline_controller_if #(.CNT_W(W)) bus ();
  pipeline_controller #(.CNT_W(W)) dut (.CLK(clk), .nRST(nrst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] ctrl();
    return {bus.pc_en, bus.ifde_en, bus.deex_en, bus.exmem_en, bus.memwb_en,
            bus.ifde_flush, bus.deex_flush, bus.halt};
  endfunction

  task automatic idle();
    bus.ihit = 1; bus.dhit = 1; bus.mem_dREN = 0; bus.mem_dWEN = 0; bus.mem_halt = 0;
    bus.dec_instr = 32'h0; bus.ex_dREN = 0; bus.ex_rfWEN = 0; bus.ex_dest = 0;
    bus.mem_dREN_dest = 0; bus.branch_taken = 0; bus.jump = 0;
  endtask

  task automatic tick(input string tag, input logic [7:0] ec, input int en);
    #1;
    check({tag, ".ctl"}, ctrl(), ec);
    check({tag, ".cnt"}, bus.stall_cycles, en);
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 0;
    #1;
    check("rst.ctl", ctrl(), OFF);
    check("rst.cnt", bus.stall_cycles, 0);
    @(negedge clk);
    nrst = 1;
    owed = 0; halted = 0; cnt_m = 0;
  endtask

  function automatic bit used(input logic [4:0] r);
    logic [5:0] op = bus.dec_instr[31:26];
    bit rt_ok = op == 6'h00 || op == 6'h04 || op == 6'h05 || op == 6'h2b;
    return r != 0 && (r == bus.dec_instr[25:21] || (rt_ok && r == bus.dec_instr[20:16]));
  endfunction

  function automatic logic [4:0] rreg();
    case ($urandom_range(3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    idle();
    @(negedge clk);
    do_reset();
    bus.ex_dREN = 1; bus.ex_dest = 8; bus.dec_instr = {OP_RTYPE, 5'd8, 5'd0, 16'h4020};
    tick("lu", STL, 0);
    idle(); tick("lu.rel", RUN, 1);
    do_reset();
    bus.ex_dREN = 1; bus.ex_dest = 9; bus.dec_instr = {OP_BEQ, 5'd0, 5'd9, 16'h0004};
    tick("bl1", STL, 0);
    bus.ex_dREN = 0; bus.ex_dest = 0; bus.mem_dREN_dest = 9;
    tick("bl2", STL, 1);
    idle(); tick("bl3", RUN, 2);
    do_reset();
    bus.ex_dREN = 1; bus.ex_dest = 9; bus.dec_instr = {OP_BEQ, 5'd0, 5'd9, 16'h0004};
    tick("dw0", STL, 0);
    bus.ex_dREN = 0; bus.ex_dest = 0; bus.mem_dREN_dest = 9; bus.mem_dREN = 1; bus.dhit = 0;
    for (int i = 0; i < 3; i++) tick($sformatf("dw%0d", i + 1), OFF, i + 1);
    bus.dhit = 1; tick("dw4", STL, 4);
    idle(); tick("dw5", RUN, 5);
    do_reset();
    bus.jump = 1; tick("jmp", RDR, 0);
    bus.ihit = 0; tick("jmp.miss", MISS, 0);
    idle(); tick("jmp.rel", RUN, 1);
    do_reset();
    bus.dec_instr = {OP_BNE, 5'd8, 5'd0, 16'h0}; bus.ex_rfWEN = 1; bus.ex_dest = 8; bus.branch_taken = 1;
    tick("balu", STL, 0);
    bus.ex_rfWEN = 0; bus.ex_dest = 0; tick("balu.rel", RDR, 1);
    idle(); bus.dec_instr = {OP_ADDI, 5'd0, 5'd8, 16'h1}; bus.ex_dREN = 1; bus.ex_dest = 8;
    tick("addi.rt", RUN, 1);
    bus.dec_instr = {OP_SW, 5'd0, 5'd8, 16'h1}; tick("sw.rt", STL, 1);
    bus.ex_dest = 0; bus.dec_instr = {OP_RTYPE, 5'd0, 5'd0, 16'h0}; tick("r0", RUN, 2);
    do_reset();
    bus.ex_dREN = 1; bus.ex_dest = 8; bus.dec_instr = {OP_RTYPE, 5'd8, 5'd0, 16'h4020};
    tick("h0", STL, 0);
    idle(); bus.mem_halt = 1; bus.mem_dREN = 1; tick("h1", RUN, 1);
    idle(); bus.ihit = 0; tick("h2", HLT, 1);
    tick("h3", HLT, 1);
    do_reset();
    idle(); bus.mem_halt = 1; bus.mem_dWEN = 1; bus.dhit = 0; tick("hw0", OFF, 0);
    bus.dhit = 1; tick("hw1", RUN, 1);
    idle(); tick("hw2", HLT, 1);
    do_reset();
    bus.ex_dREN = 1; bus.ex_dest = 9; bus.dec_instr = {OP_BEQ, 5'd0, 5'd9, 16'h0004};
    tick("rh0", STL, 0);
    do_reset();
    idle(); tick("rh1", RUN, 0);
    do_reset();
    bus.ihit = 0;
    for (int i = 0; i < 40; i++) tick("sat", MISS, i < CMAX ? i : CMAX);
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [7:0] exp;
      logic [5:0] op;
      bit wt, br;
      int len;
      if ($urandom_range(99) < 2) begin
        do_reset();
        continue;
      end
      bus.dec_instr = {ops[$urandom_range(6)], rreg(), rreg(), 16'($urandom)};
      bus.ex_dREN = $urandom_range(9) < 3; bus.ex_rfWEN = $urandom_range(1) == 1; bus.ex_dest = rreg();
      bus.mem_dREN_dest = rreg(); bus.mem_dREN = $urandom_range(9) < 3; bus.mem_dWEN = $urandom_range(9) < 1;
      bus.dhit = $urandom_range(9) < 7; bus.ihit = $urandom_range(9) < 8;
      bus.branch_taken = $urandom_range(99) < 15; bus.jump = $urandom_range(99) < 10;
      bus.mem_halt = $urandom_range(99) < 2;
      #1;
      op = bus.dec_instr[31:26];
      wt = (bus.mem_dREN || bus.mem_dWEN) && !bus.dhit;
      br = op == 6'h04 || op == 6'h05;
      len = 0;
      if (bus.ex_dREN && used(bus.ex_dest)) len = br ? 2 : 1;
      else if (br && ((bus.ex_rfWEN && used(bus.ex_dest)) || (owed == 0 && used(bus.mem_dREN_dest)))) len = 1;
      exp = halted ? HLT : wt ? OFF : (owed > 0 || len > 0) ? STL : !bus.ihit ? MISS :
            (bus.branch_taken || bus.jump) ? RDR : RUN;
      check("rnd.ctl", ctrl(), exp);
      check("rnd.cnt", bus.stall_cycles, cnt_m);
      if (!halted && !exp[7] && cnt_m < CMAX) cnt_m++;
      if (!halted && !wt) begin
        owed = owed > 0 ? owed - 1 : (len > 0 ? len - 1 : 0);
        if (bus.mem_halt) halted = 1;
      end
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
